// File: rtl/btn_pkg.sv
// btn_pkg: shared button constants, repeat FSM states and default timing
package btn_pkg;
  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED = 1'b0;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int REPEAT_500MS = CLK_HZ / 2;
  localparam int REPEAT_100MS = CLK_HZ / 10;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// debounce_channel: one button's synchronizer, debounce, strobes and optional auto-repeat (BTN_AUTOREPEAT_EN)
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY = REPEAT_500MS,
  parameter int REPEAT_PERIOD = REPEAT_100MS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_n,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, stable_n, mismatch, flip, accept_press, accept_release, rep_pulse;
  logic [CW-1:0] cnt;
  assign mismatch = sync2 != stable_n;
  assign flip = mismatch && cnt == DB_LAST;
  assign accept_press = flip && stable_n == BTN_RELEASED;
  assign accept_release = flip && stable_n == BTN_PRESSED;
  assign btn_level = stable_n == BTN_PRESSED;
  // two-flop synchronizer feeding a saturating mismatch counter that flips the stable state
  always_ff @(posedge Clk)
    if (Reset) begin
      sync1 <= BTN_RELEASED;
      sync2 <= BTN_RELEASED;
      stable_n <= BTN_RELEASED;
      cnt <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      stable_n <= flip ? ~stable_n : stable_n;
      cnt <= (!mismatch || flip) ? '0 : (cnt == '1 ? cnt : cnt + 1'b1);
    end
  // registered strobes aligned with the edge on which the level changes
  always_ff @(posedge Clk)
    if (Reset) begin
      btn_press <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press <= accept_press || rep_pulse;
      btn_release <= accept_release;
    end
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
  rep_state_t state, state_nx;
  logic [CW-1:0] rcnt, rcnt_nx;
  // repeat FSM state and hold-time counter
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= IDLE;
      rcnt <= '0;
    end else begin
      state <= state_nx;
      rcnt <= rcnt_nx;
    end
  // accepted press starts the hold timer; release or idle parks the FSM with no pulse
  always_comb begin
    state_nx = state;
    rcnt_nx = '0;
    rep_pulse = 1'b0;
    if (accept_press) state_nx = HOLD;
    else if (accept_release || state == IDLE) state_nx = IDLE;
    else if (state == HOLD && rcnt == DLY_LAST) begin
      state_nx = REPEAT;
      rep_pulse = 1'b1;
    end else if (state == REPEAT && rcnt == PER_LAST) rep_pulse = 1'b1;
    else rcnt_nx = rcnt == '1 ? rcnt : rcnt + 1'b1;
  end
`else
  assign rep_pulse = 1'b0;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions NUM_BTN raw active-low keys into clean levels and strobes (BTN_AUTOREPEAT_EN adds auto-repeat)
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY = REPEAT_500MS,
  parameter int REPEAT_PERIOD = REPEAT_100MS
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] btn_n_i,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .Clk(Clk),
      .Reset(Reset),
      .btn_n(btn_n_i[i]),
      .btn_level(btn_level[i]),
      .btn_press(btn_press[i]),
      .btn_release(btn_release[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks against a sample-window reference model
module tb_button_conditioner;
  localparam int NB = 4, DB = 4, RD = 10, RP = 3;
  logic Clk = 1'b0, Reset = 1'b1;
  logic [NB-1:0] btn_n_i = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release;
  int checks = 0, errors = 0;
  logic [NB-1:0] samp[$];
  logic [NB-1:0] m_lvl = '0, m_press = '0, m_rel = '0;
  int m_hold[NB];

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .btn_n_i(btn_n_i),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A level flips once the last DB values seen past the two sync stages all oppose it.
  task automatic step(input logic rst, input logic [NB-1:0] b);
    logic [NB-1:0] prev, s;
    bit all;
    Reset = rst;
    btn_n_i = b;
    @(posedge Clk);
    #1;
    prev = m_lvl;
    m_press = '0;
    m_rel = '0;
    if (rst) begin
      samp.delete();
      repeat (DB + 2) samp.push_back('1);
      m_lvl = '0;
    end else begin
      samp.push_back(b);
      void'(samp.pop_front());
      for (int c = 0; c < NB; c++) begin
        all = 1;
        for (int j = 0; j < DB; j++) begin
          s = samp[j];
          if (s[c] !== m_lvl[c]) all = 0;
        end
        if (all) m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c] && !prev[c]) begin
          m_press[c] = 1'b1;
          m_hold[c] = 0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (m_lvl[c]) begin
          m_hold[c]++;
          m_press[c] = m_hold[c] >= RD && (m_hold[c] - RD) % RP == 0;
        end
`endif
      end
      m_rel = prev & ~m_lvl;
    end
    check("level", int'(btn_level), int'(m_lvl));
    check("press", int'(btn_press), int'(m_press));
    check("release", int'(btn_release), int'(m_rel));
    check("press_and_release", int'(btn_press & btn_release), 0);
  endtask

  initial begin
    logic [NB-1:0] cur;
    int dur[NB];
    int n, n_late;
    bit seen;
    repeat (DB + 2) samp.push_back('1);
    for (int c = 0; c < NB; c++) m_hold[c] = 0;
    repeat (3) step(1'b1, '1);
    check("reset_outputs", int'({btn_level, btn_press, btn_release}), 0);
    repeat (20) step(1'b0, '1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b1101);
      if (e == 5) check("t2_level_e5", int'(btn_level[1]), 0);
      if (e == 6) begin
        check("t2_level_e6", int'(btn_level[1]), 1);
        check("t2_press_e6", int'(btn_press[1]), 1);
        check("t2_others", int'(btn_level & 4'b1101), 0);
      end
      if (e == 7) check("t2_press_e7", int'(btn_press[1]), 0);
    end
    repeat (8) step(1'b0, '1);
    seen = 0;
    repeat (5) begin
      repeat (3) begin
        step(1'b0, 4'b1011);
        seen |= btn_level[2] | btn_press[2] | btn_release[2];
      end
      repeat (2) begin
        step(1'b0, 4'b1111);
        seen |= btn_level[2] | btn_press[2] | btn_release[2];
      end
    end
    check("t3_glitch", int'(seen), 0);
    repeat (20) step(1'b0, 4'b1110);
    check("t4_held", int'(btn_level[0]), 1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b1111);
      if (e == 5) check("t4_release_e5", int'(btn_release[0]), 0);
      if (e == 6) check("t4_release_e6", int'(btn_release[0]), 1);
      if (e == 7) check("t4_release_e7", int'(btn_release[0]), 0);
    end
    repeat (4) step(1'b0, '1);
    step(1'b0, 4'b0111);
    step(1'b0, 4'b0111);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b0111);
    check("t5_no_level_in_reset", int'(btn_level[3]), 0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 4'b0111);
      if (e == 5) check("t5_press_e5", int'(btn_press[3]), 0);
      if (e == 6) check("t5_press_e6", int'(btn_press[3]), 1);
    end
    repeat (8) step(1'b0, '1);
    n = 0;
    repeat (30) begin
      step(1'b0, 4'b1101);
      n += int'(btn_press[1]);
    end
`ifdef BTN_AUTOREPEAT_EN
    check("t6_press_count", n, 6);
`else
    check("t6_press_count", n, 1);
`endif
    n_late = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, 4'b1111);
      if (e >= 6) n_late += int'(btn_press[1]);
    end
    check("t6_after_release", n_late, 0);
    cur = '1;
    for (int c = 0; c < NB; c++) dur[c] = $urandom_range(1, 2 * DB + 2);
    repeat (800) begin
      for (int c = 0; c < NB; c++) begin
        dur[c]--;
        if (dur[c] <= 0) begin
          cur[c] = ~cur[c];
          dur[c] = $urandom_range(1, 3 * DB + 12);
        end
      end
      step($urandom_range(0, 149) == 0, cur);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
